hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RISC-V CPU; produces the `noop` that drives the Control unit's `noop_i`, plus PC, IF/ID and pipe-freeze enables.
- Handles three hazards:
  - load-use: one bubble.
  - taken branch resolved in ID: IF/ID flush.
  - fixed-latency data-memory access: multi-cycle whole-pipe freeze, sequenced by an FSM plus down-counter.
- Sits in the ID stage, beside Control and the IF/ID and ID/EX registers.

Parameters:
- MEM_LAT, 3, total cycles a load/store occupies MEM (legal 1..16); 1 means no memory stall.
- CNT_W, 4, width of the memory-wait counter; must hold MEM_LAT-1.
- PERF_W, 32, width of the performance counters (optional feature only).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- idex_memread_i  in  1  instruction in EX is a load.
- idex_rd_i  in  5  rd of the instruction in EX.
- ifid_rs1_i  in  5  rs1 of the instruction in ID.
- ifid_rs2_i  in  5  rs2 of the instruction in ID.
- ifid_use_rs2_i  in  1  ID instruction reads rs2 (R-type, store, branch).
- branch_taken_i  in  1  ID-stage branch compare resolved taken.
- exmem_memacc_i  in  1  instruction in MEM is a load or store.
- noop_o  out  1  to Control `noop_i`; inserts a bubble into ID/EX.
- pc_write_o  out  1  PC update enable.
- ifid_write_o  out  1  IF/ID load enable.
- ifid_flush_o  out  1  IF/ID clear (becomes nop).
- pipe_stall_o  out  1  hold ID/EX, EX/MEM and MEM/WB.
- perf_loaduse_o  out  PERF_W  load-use bubble count.
- perf_memstall_o  out  PERF_W  memory stall cycle count.
- perf_flush_o  out  PERF_W  flush count.

Behaviour:
- Reset: asynchronous on rst_i low.
  - Asserting rst_i mid-stall aborts the stall immediately.
  - While in reset: state=RUN, cnt=0, all perf counters 0.
  - Output values while in reset: noop_o=0, pc_write_o=1, ifid_write_o=1, ifid_flush_o=0, pipe_stall_o=0.
- Outputs are combinational (Mealy) from state, cnt and inputs. Zero latency: they act in the same cycle the hazard is visible.
- States: RUN, MWAIT.
- Memory freeze (highest priority):
  - Trigger: RUN with exmem_memacc_i=1 and MEM_LAT>1.
    - Outputs this cycle: pipe_stall_o=1, pc_write_o=0, ifid_write_o=0, noop_o=0, ifid_flush_o=0.
    - Next: state MWAIT, cnt<=MEM_LAT-2.
  - MWAIT, cnt!=0: same freeze outputs; cnt<=cnt-1.
  - MWAIT, cnt==0 (release cycle): pipe_stall_o=0; state<=RUN.
    - exmem_memacc_i is ignored in this cycle, so the same access cannot retrigger.
    - Load-use and flush logic are evaluated normally in this cycle.
  - Net effect: exactly MEM_LAT-1 freeze cycles per access.
  - A new access in the cycle after release retriggers (back-to-back loads/stores each pay MEM_LAT-1).
- Load-use (when not frozen):
  - Condition: idex_memread_i & idex_rd_i!=0 & (idex_rd_i==ifid_rs1_i | (ifid_use_rs2_i & idex_rd_i==ifid_rs2_i)).
  - Response: noop_o=1, pc_write_o=0, ifid_write_o=0. Exactly one bubble, because the load leaves EX at the next edge.
  - rd==x0 never stalls.
- Branch flush (when not frozen):
  - branch_taken_i=1 → ifid_flush_o=1.
  - If load-use is active in the same cycle, the flush is suppressed: branch operands are not yet valid and the branch re-resolves next cycle.
- Priority: freeze > load-use > flush.
- Outputs in freeze and load-use cycles: pipe_stall_o and noop_o are never both 1; ifid_flush_o is never 1 together with ifid_write_o=0.

Optional Feature:
- HAZARD_PERF_EN defined:
  - perf_loaduse_o increments per load-use bubble cycle.
  - perf_memstall_o increments per freeze cycle.
  - perf_flush_o increments per flush cycle.
  - All three saturate at all-ones; reset to 0.
- HAZARD_PERF_EN undefined: the three perf outputs are tied to 0 and no counter flops are synthesized. The port list is unchanged.

Decomposition:
- Shared package hazard_pkg holds: state encoding (RUN=1'b0, MWAIT=1'b1), the x0 register constant, and the opcode constants already used by Control (R=0110011, LOAD=0000011, STORE=0100011, BRANCH=1100011).
- One sub-module: hazard_perf_cnt, a single saturating PERF_W counter with enable. It is instantiated three times, under HAZARD_PERF_EN only.

Test Plan:
- Load-use: idex_memread_i=1, idex_rd_i=5, ifid_rs1_i=5 → noop_o=1, pc_write_o=0, ifid_write_o=0 for 1 cycle. Repeat with rd=0 → no stall.
- rs2 gating: rd=7, rs2=7, ifid_use_rs2_i=0 → no stall; with ifid_use_rs2_i=1 → stall.
- Memory freeze, MEM_LAT=3: exmem_memacc_i held high 3 cycles → pipe_stall_o=1,1,0; state back to RUN. A new access on the next cycle → freeze restarts.
- Priority: memacc, load-use and branch_taken_i all high in RUN → only the freeze is visible. In the release cycle with load-use plus branch → noop_o=1, ifid_flush_o=0.
- Reset mid-freeze: rst_i low during MWAIT with cnt=1 → outputs go to reset values immediately. After release, no residual stall.
- HAZARD_PERF_EN: run the three scenarios above → perf_loaduse_o=1, perf_memstall_o=2, perf_flush_o=1. With the macro undefined → all three 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the ID-stage hazard controller: FSM encoding,
// the x0 register index and the opcode constants also used by Control.
package hazard_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    MWAIT = 1'b1
  } hz_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter with enable; holds at all-ones instead of wrapping.
module hazard_perf_cnt #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                  r_cnt <= '0;
    else if (i_en && r_cnt != '1)  r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: memory freeze > load-use bubble > branch flush.
// Optional performance counters are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_LAT = 3,
  parameter int CNT_W   = 4,
  parameter int PERF_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              idex_memread_i,
  input  logic [4:0]        idex_rd_i,
  input  logic [4:0]        ifid_rs1_i,
  input  logic [4:0]        ifid_rs2_i,
  input  logic              ifid_use_rs2_i,
  input  logic              branch_taken_i,
  input  logic              exmem_memacc_i,
  output logic              noop_o,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              pipe_stall_o,
  output logic [PERF_W-1:0] perf_loaduse_o,
  output logic [PERF_W-1:0] perf_memstall_o,
  output logic [PERF_W-1:0] perf_flush_o
);

  // The trigger cycle is itself a freeze cycle, so MWAIT only covers the rest.
  localparam bit               MEM_STALL_EN = (MEM_LAT > 1);
  localparam logic [CNT_W-1:0] CNT_INIT     = CNT_W'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);

  hz_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_freeze;
  logic             w_loaduse;

  assign w_loaduse = idex_memread_i && (idex_rd_i != REG_X0) &&
                     ((idex_rd_i == ifid_rs1_i) ||
                      (ifid_use_rs2_i && (idex_rd_i == ifid_rs2_i)));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_freeze     = 1'b0;
    noop_o       = 1'b0;
    pc_write_o   = 1'b1;
    ifid_write_o = 1'b1;
    ifid_flush_o = 1'b0;
    pipe_stall_o = 1'b0;

    case (r_state)
      RUN: begin
        if (MEM_STALL_EN && exmem_memacc_i) begin
          w_freeze    = 1'b1;
          w_state_nxt = MWAIT;
          w_cnt_nxt   = CNT_INIT;
        end
      end
      MWAIT: begin
        // Release cycle ignores memacc so the access in MEM cannot retrigger.
        if (r_cnt != '0) begin
          w_freeze  = 1'b1;
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase

    if (rst_i) begin
      if (w_freeze) begin
        pipe_stall_o = 1'b1;
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
      end else if (w_loaduse) begin
        noop_o       = 1'b1;
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
      end else if (branch_taken_i) begin
        ifid_flush_o = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt #(.W(PERF_W)) u_perf_loaduse (
    .i_clk(clk_i), .i_rst_n(rst_i), .i_en(noop_o),       .o_cnt(perf_loaduse_o)
  );
  hazard_perf_cnt #(.W(PERF_W)) u_perf_memstall (
    .i_clk(clk_i), .i_rst_n(rst_i), .i_en(pipe_stall_o), .o_cnt(perf_memstall_o)
  );
  hazard_perf_cnt #(.W(PERF_W)) u_perf_flush (
    .i_clk(clk_i), .i_rst_n(rst_i), .i_en(ifid_flush_o), .o_cnt(perf_flush_o)
  );
`else
  assign perf_loaduse_o  = '0;
  assign perf_memstall_o = '0;
  assign perf_flush_o    = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (MEM_LAT=3); expected output vectors
// {noop,pc_write,ifid_write,flush,stall} are queued as stimulus is applied.
module tb_hazard_ctrl;

  localparam int PERF_W = 32;

  typedef struct packed {
    logic       memread;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use2;
    logic       br;
    logic       memacc;
  } stim_t;

  localparam logic [4:0] E_IDLE  = 5'b01100;
  localparam logic [4:0] E_BUB   = 5'b10000;
  localparam logic [4:0] E_FRZ   = 5'b00001;
  localparam logic [4:0] E_FLUSH = 5'b01110;

  logic clk, rst_n;
  logic memread, use2, br, memacc;
  logic [4:0] rd, rs1, rs2;
  logic noop, pcw, ifw, flush, stall;
  logic [PERF_W-1:0] p_lu, p_ms, p_fl;

  logic [4:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int m_lu = 0, m_ms = 0, m_fl = 0;

  hazard_ctrl #(.MEM_LAT(3), .CNT_W(4), .PERF_W(PERF_W)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .idex_memread_i(memread), .idex_rd_i(rd),
    .ifid_rs1_i(rs1), .ifid_rs2_i(rs2), .ifid_use_rs2_i(use2),
    .branch_taken_i(br), .exmem_memacc_i(memacc),
    .noop_o(noop), .pc_write_o(pcw), .ifid_write_o(ifw),
    .ifid_flush_o(flush), .pipe_stall_o(stall),
    .perf_loaduse_o(p_lu), .perf_memstall_o(p_ms), .perf_flush_o(p_fl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus and queue its expected outputs; the perf model
  // follows the expected vector, not the DUT.
  task automatic apply(input stim_t s, input logic [4:0] e);
    memread = s.memread; rd = s.rd; rs1 = s.rs1; rs2 = s.rs2;
    use2 = s.use2; br = s.br; memacc = s.memacc;
    exp_q.push_back(e);
    if (rst_n) begin
      m_lu += int'(e[4]);
      m_fl += int'(e[1]);
      m_ms += int'(e[0]);
    end
  endtask

  function automatic stim_t mk(logic mr, logic [4:0] d, logic [4:0] s1, logic [4:0] s2,
                               logic u2, logic b, logic ma);
    stim_t s;
    s.memread = mr; s.rd = d; s.rs1 = s1; s.rs2 = s2; s.use2 = u2; s.br = b; s.memacc = ma;
    return s;
  endfunction

  task automatic check_perf(input string tag);
    logic [PERF_W-1:0] e_lu, e_ms, e_fl;
`ifdef HAZARD_PERF_EN
    e_lu = PERF_W'(m_lu); e_ms = PERF_W'(m_ms); e_fl = PERF_W'(m_fl);
`else
    e_lu = '0; e_ms = '0; e_fl = '0;
`endif
    checks++;
    if (p_lu !== e_lu || p_ms !== e_ms || p_fl !== e_fl) begin
      errors++;
      $display("FAIL perf_%s got lu=%0d ms=%0d fl=%0d exp lu=%0d ms=%0d fl=%0d",
               tag, p_lu, p_ms, p_fl, e_lu, e_ms, e_fl);
    end
  endtask

  task automatic test_reset();
    logic [4:0] got, exp;
    rst_n = 1'b0;
    apply(mk(1, 5'd5, 5'd5, 5'd0, 0, 1, 1), E_IDLE);
    @(negedge clk);
    got = {noop, pcw, ifw, flush, stall};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL reset_outputs got %b exp %b", got, exp);
    end
    check_perf("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_loaduse();
    stim_t st[4];
    logic [4:0] ex[4];
    logic [4:0] got, exp;
    st[0] = mk(1, 5'd5, 5'd5, 5'd9, 0, 0, 0); ex[0] = E_BUB;
    st[1] = mk(0, 5'd5, 5'd5, 5'd9, 0, 0, 0); ex[1] = E_IDLE;
    st[2] = mk(1, 5'd0, 5'd0, 5'd0, 1, 0, 0); ex[2] = E_IDLE;
    st[3] = mk(1, 5'd5, 5'd6, 5'd5, 0, 0, 0); ex[3] = E_IDLE;
    for (int i = 0; i < 4; i++) begin
      apply(st[i], ex[i]);
      @(negedge clk);
      got = {noop, pcw, ifw, flush, stall};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL loaduse row %0d got %b exp %b", i, got, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rs2_gate();
    stim_t st[3];
    logic [4:0] ex[3];
    logic [4:0] got, exp;
    st[0] = mk(1, 5'd7, 5'd1, 5'd7, 0, 0, 0); ex[0] = E_IDLE;
    st[1] = mk(1, 5'd7, 5'd1, 5'd7, 1, 0, 0); ex[1] = E_BUB;
    st[2] = mk(0, 5'd7, 5'd1, 5'd7, 1, 0, 0); ex[2] = E_IDLE;
    for (int i = 0; i < 3; i++) begin
      apply(st[i], ex[i]);
      @(negedge clk);
      got = {noop, pcw, ifw, flush, stall};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL rs2_gate row %0d got %b exp %b", i, got, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_memfreeze();
    stim_t st[7];
    logic [4:0] ex[7];
    logic [4:0] got, exp;
    st[0] = mk(0, 0, 0, 0, 0, 0, 1); ex[0] = E_FRZ;
    st[1] = mk(0, 0, 0, 0, 0, 0, 1); ex[1] = E_FRZ;
    st[2] = mk(0, 0, 0, 0, 0, 0, 1); ex[2] = E_IDLE;
    st[3] = mk(0, 0, 0, 0, 0, 0, 1); ex[3] = E_FRZ;
    st[4] = mk(0, 0, 0, 0, 0, 0, 1); ex[4] = E_FRZ;
    st[5] = mk(0, 0, 0, 0, 0, 0, 0); ex[5] = E_IDLE;
    st[6] = mk(0, 0, 0, 0, 0, 0, 0); ex[6] = E_IDLE;
    for (int i = 0; i < 7; i++) begin
      apply(st[i], ex[i]);
      @(negedge clk);
      got = {noop, pcw, ifw, flush, stall};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL memfreeze row %0d got %b exp %b", i, got, exp);
      end
      @(posedge clk); #1;
    end
    check_perf("memfreeze");
  endtask

  task automatic test_priority();
    stim_t st[5];
    logic [4:0] ex[5];
    logic [4:0] got, exp;
    st[0] = mk(1, 5'd3, 5'd3, 5'd0, 0, 1, 1); ex[0] = E_FRZ;
    st[1] = mk(1, 5'd3, 5'd3, 5'd0, 0, 1, 1); ex[1] = E_FRZ;
    st[2] = mk(1, 5'd3, 5'd3, 5'd0, 0, 1, 1); ex[2] = E_BUB;
    st[3] = mk(0, 5'd3, 5'd3, 5'd0, 0, 1, 0); ex[3] = E_FLUSH;
    st[4] = mk(0, 0, 0, 0, 0, 0, 0);          ex[4] = E_IDLE;
    for (int i = 0; i < 5; i++) begin
      apply(st[i], ex[i]);
      @(negedge clk);
      got = {noop, pcw, ifw, flush, stall};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL priority row %0d got %b exp %b", i, got, exp);
      end
      @(posedge clk); #1;
    end
    check_perf("priority");
  endtask

  task automatic test_reset_midfreeze();
    stim_t st[6];
    logic [4:0] ex[6];
    logic [4:0] got, exp;
    st[0] = mk(0, 0, 0, 0, 0, 0, 1);          ex[0] = E_FRZ;
    st[1] = mk(1, 5'd4, 5'd4, 5'd0, 0, 1, 1); ex[1] = E_IDLE;
    st[2] = mk(0, 0, 0, 0, 0, 0, 0);          ex[2] = E_IDLE;
    st[3] = mk(0, 0, 0, 0, 0, 0, 1);          ex[3] = E_FRZ;
    st[4] = mk(0, 0, 0, 0, 0, 0, 1);          ex[4] = E_FRZ;
    st[5] = mk(0, 0, 0, 0, 0, 0, 0);          ex[5] = E_IDLE;
    for (int i = 0; i < 6; i++) begin
      // Row 1 lands in MWAIT with cnt=1; reset is dropped right there.
      if (i == 1) begin
        rst_n = 1'b0;
        m_lu = 0; m_ms = 0; m_fl = 0;
      end
      apply(st[i], ex[i]);
      @(negedge clk);
      got = {noop, pcw, ifw, flush, stall};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL reset_mid row %0d got %b exp %b", i, got, exp);
      end
      if (i == 1) check_perf("in_reset");
      @(posedge clk); #1;
      if (i == 1) rst_n = 1'b1;
    end
    check_perf("after_reset");
  endtask

  initial begin
    rst_n = 1'b0;
    memread = 0; rd = 0; rs1 = 0; rs2 = 0; use2 = 0; br = 0; memacc = 0;
    #12;
    test_reset();
    test_loaduse();
    test_rs2_gate();
    test_memfreeze();
    test_priority();
    test_reset_midfreeze();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
